// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war input stage.
// Holds the per-key state enum and the default debounce length.
// Imported by key_conditioner and tug_input.
package tug_pkg;

  // Debounced key state tracked by each key_conditioner FSM.
  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } key_state_t;

  // Synchronized cycles a new level must persist before it is accepted.
  localparam int DEBOUNCE_DEFAULT = 4;

endpackage : tug_pkg

// File: rtl/tug_key_conditioner.sv
// Purpose: synchronize, debounce and edge-detect one raw player key.
// Latency: candidate pulse is high the cycle after edge DEBOUNCE_CYCLES+2
// from the first edge sampling the key high. There is no backpressure.
// Ports: clk, reset (sync, active-high), i_key (raw async key),
//        o_cand (one-cycle pulse per accepted press).
module key_conditioner
  import tug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key,
  output logic o_cand
);

  // Counter value on which the next mismatching cycle completes the debounce.
  localparam logic [7:0] LP_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_acc;
  logic [7:0] r_cnt;
  key_state_t r_state;
  key_state_t w_state_nxt;
  logic       w_rise;
  logic       r_cand;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_acc   <= 1'b0;
      r_cnt   <= 8'd0;
      r_state <= RELEASED;
      r_cand  <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      // Any return to the accepted level discards the partial count, so
      // short excursions never reach the accept point.
      if (r_sync2 == r_acc) begin
        r_cnt <= 8'd0;
      end else if (r_cnt == LP_LAST) begin
        r_acc <= r_sync2;
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
      r_state <= w_state_nxt;
      r_cand  <= w_rise;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rise      = 1'b0;
    case (r_state)
      RELEASED: begin
        if (r_acc) begin
          w_state_nxt = PRESSED;
          w_rise      = 1'b1;
        end
      end
      PRESSED: begin
        if (!r_acc) begin
          w_state_nxt = RELEASED;
        end
      end
      default: w_state_nxt = RELEASED;
    endcase
  end

  assign o_cand = r_cand;

endmodule : key_conditioner

// File: rtl/tug_input.sv
// Purpose: condition both player keys and arbitrate them into press/tie pulses.
// Latency: press output high the cycle after edge DEBOUNCE_CYCLES+3 from the key rising.
// Backpressure: none; freeze suppresses outputs while conditioning keeps running.
// Ports: clk, reset (sync, active-high), key_l/key_r (raw async keys),
//        freeze (lockout), l_press/r_press/tie (registered one-cycle pulses).
module tug_input
  import tug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l,
  input  logic key_r,
  input  logic freeze,
  output logic l_press,
  output logic r_press,
  output logic tie
);

  logic w_cand_l;
  logic w_cand_r;
  logic r_l_press;
  logic r_r_press;
  logic r_tie;

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_l (
    .clk    (clk),
    .reset  (reset),
    .i_key  (key_l),
    .o_cand (w_cand_l)
  );

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_r (
    .clk    (clk),
    .reset  (reset),
    .i_key  (key_r),
    .o_cand (w_cand_r)
  );

  // Simultaneous presses cancel into a tie; candidates are single-cycle, so
  // none of these registers can be high two cycles running.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_l_press <= 1'b0;
      r_r_press <= 1'b0;
      r_tie     <= 1'b0;
    end else begin
      r_l_press <= w_cand_l & ~w_cand_r & ~freeze;
      r_r_press <= w_cand_r & ~w_cand_l & ~freeze;
      r_tie     <= w_cand_l &  w_cand_r & ~freeze;
    end
  end

  assign l_press = r_l_press;
  assign r_press = r_r_press;
  assign tie     = r_tie;

endmodule : tug_input
